// File: rtl/alu_rx_pkg.sv
// Shared types and helpers for the serial ALU command receiver.
//   operation_t  : legal ALU op codes carried in the control frame
//   frame_type_t : value of the type bit in each frame
//   rx_state_t   : bit-level deserialiser states
//   ERR_*_IDX    : bit positions inside cmd_err
//   crc4_d68     : CRC-4 (x^4+x+1, init 0) over the 68-bit {B, A, 1, op} word
//   op_legal     : true for the op codes the ALU core implements
package alu_rx_pkg;

    typedef enum logic [2:0] {
        OP_AND = 3'b000,
        OP_OR  = 3'b001,
        OP_ADD = 3'b100,
        OP_SUB = 3'b101
    } operation_t;

    typedef enum logic {
        FRAME_DATA = 1'b0,
        FRAME_CTRL = 1'b1
    } frame_type_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_SHIFT = 2'd1,
        RX_CHECK = 2'd2
    } rx_state_t;

    localparam int ERR_DATA_IDX = 2;
    localparam int ERR_CRC_IDX  = 1;
    localparam int ERR_OP_IDX   = 0;

    // Serial LFSR form, MSB of the input word first.
    function automatic logic [3:0] crc4_d68(input logic [67:0] d);
        logic [3:0] crc;
        logic       fb;
        crc = 4'h0;
        for (int i = 67; i >= 0; i--) begin
            fb  = crc[3] ^ d[i];
            crc = {crc[2:0], 1'b0} ^ (fb ? 4'b0011 : 4'b0000);
        end
        return crc;
    endfunction

    function automatic logic op_legal(input logic [2:0] op);
        logic ok;
        case (op)
            OP_AND, OP_OR, OP_ADD, OP_SUB: ok = 1'b1;
            default:                       ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/alu_rx_frame.sv
// Bit-level deserialiser for 11-bit frames {start=0, type, payload[7:0], stop}.
//   clk, rst_n   : clock, asynchronous active-low reset
//   sin          : serial input, idles high
//   frame_valid  : one-cycle strobe while the completed frame is presented
//   frame_type   : type bit of the completed frame
//   payload      : 8 payload bits, first received bit in [7]
//   stop_ok      : received stop bit was 1
module alu_rx_frame
    import alu_rx_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sin,
    output logic        frame_valid,
    output frame_type_t frame_type,
    output logic [7:0]  payload,
    output logic        stop_ok
);

    rx_state_t   state_reg, state_next;
    logic [3:0]  bit_cnt_reg, bit_cnt_next;
    logic [9:0]  shift_reg, shift_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= RX_IDLE;
            bit_cnt_reg <= 4'd0;
            shift_reg   <= 10'd0;
        end else begin
            state_reg   <= state_next;
            bit_cnt_reg <= bit_cnt_next;
            shift_reg   <= shift_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        bit_cnt_next = bit_cnt_reg;
        shift_next   = shift_reg;
        case (state_reg)
            RX_IDLE: begin
                if (!sin) begin
                    state_next   = RX_SHIFT;
                    bit_cnt_next = 4'd0;
                end
            end
            RX_SHIFT: begin
                // type, 8 payload bits and stop bit: 10 bits after the start bit
                shift_next   = {shift_reg[8:0], sin};
                bit_cnt_next = bit_cnt_reg + 4'd1;
                if (bit_cnt_reg == 4'd9) begin
                    state_next = RX_CHECK;
                end
            end
            RX_CHECK: begin
                // sin is ignored here, so a start bit in this cycle is missed
                state_next = RX_IDLE;
            end
            default: begin
                state_next = RX_IDLE;
            end
        endcase
    end

    assign frame_valid = (state_reg == RX_CHECK);
    assign frame_type  = frame_type_t'(shift_reg[9]);
    assign payload     = shift_reg[8:1];
    assign stop_ok     = shift_reg[0];

endmodule

// File: rtl/alu_serial_rx.sv
// Serial command receiver: assembles DATA_FRAMES data bytes and one control
// frame into {B, A, op}, classifies errors and offers the command over
// a valid/ready handshake.
//   clk, rst_n  : clock, asynchronous active-low reset
//   sin         : serial input
//   cmd_ready   : consumer accepts the held command
//   cmd_valid   : command held on cmd_a/cmd_b/cmd_op/cmd_err
//   cmd_err     : {ERR_DATA, ERR_CRC, ERR_OP}, at most one bit set
//   overrun     : one-cycle pulse when a new command is dropped
module alu_serial_rx
    import alu_rx_pkg::*;
#(
    parameter int DATA_FRAMES = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sin,
    input  logic        cmd_ready,
    output logic        cmd_valid,
    output logic [31:0] cmd_a,
    output logic [31:0] cmd_b,
    output logic [2:0]  cmd_op,
    output logic [2:0]  cmd_err,
    output logic        overrun
);

    logic        frame_valid;
    frame_type_t frame_type;
    logic [7:0]  payload;
    logic        stop_ok;

    alu_rx_frame u_frame (
        .clk         (clk),
        .rst_n       (rst_n),
        .sin         (sin),
        .frame_valid (frame_valid),
        .frame_type  (frame_type),
        .payload     (payload),
        .stop_ok     (stop_ok)
    );

    // {B, A}: first byte received ends up in B[31:24]
    logic [63:0] ba_reg;
    logic [3:0]  data_cnt_reg;
    logic        bad_seq_reg;

    logic        data_done;
    logic        ctrl_done;
    logic [2:0]  rx_op;
    logic [3:0]  rx_crc;
    logic [2:0]  err_next;

    assign data_done = frame_valid && stop_ok && (frame_type == FRAME_DATA);
    assign ctrl_done = frame_valid && stop_ok && (frame_type == FRAME_CTRL);
    assign rx_op     = payload[6:4];
    assign rx_crc    = payload[3:0];

    always_comb begin
        err_next = 3'b000;
        if ((data_cnt_reg != 4'(DATA_FRAMES)) || bad_seq_reg) begin
            err_next[ERR_DATA_IDX] = 1'b1;
        end else if (rx_crc != crc4_d68({ba_reg, 1'b1, rx_op})) begin
            err_next[ERR_CRC_IDX] = 1'b1;
        end else if (!op_legal(rx_op)) begin
            err_next[ERR_OP_IDX] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ba_reg       <= 64'd0;
            data_cnt_reg <= 4'd0;
            bad_seq_reg  <= 1'b0;
        end else if (frame_valid) begin
            if (!stop_ok) begin
                // framing error: the frame is dropped, the command is tainted
                bad_seq_reg <= 1'b1;
            end else if (frame_type == FRAME_DATA) begin
                ba_reg <= {ba_reg[55:0], payload};
                if (data_cnt_reg != 4'd15) begin
                    data_cnt_reg <= data_cnt_reg + 4'd1;
                end
            end else begin
                data_cnt_reg <= 4'd0;
                bad_seq_reg  <= 1'b0;
            end
        end
    end

    // Output handshake
    logic        cmd_valid_reg;
    logic [31:0] cmd_a_reg;
    logic [31:0] cmd_b_reg;
    logic [2:0]  cmd_op_reg;
    logic [2:0]  cmd_err_reg;
    logic        overrun_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_valid_reg <= 1'b0;
            cmd_a_reg     <= 32'd0;
            cmd_b_reg     <= 32'd0;
            cmd_op_reg    <= 3'd0;
            cmd_err_reg   <= 3'd0;
            overrun_reg   <= 1'b0;
        end else begin
            overrun_reg <= 1'b0;
            if (ctrl_done) begin
                // a command accepted on this same edge frees the slot
                if (!cmd_valid_reg || cmd_ready) begin
                    cmd_valid_reg <= 1'b1;
                    cmd_b_reg     <= ba_reg[63:32];
                    cmd_a_reg     <= ba_reg[31:0];
                    cmd_op_reg    <= rx_op;
                    cmd_err_reg   <= err_next;
                end else begin
                    overrun_reg <= 1'b1;
                end
            end else if (cmd_valid_reg && cmd_ready) begin
                cmd_valid_reg <= 1'b0;
            end
        end
    end

    assign cmd_valid = cmd_valid_reg;
    assign cmd_a     = cmd_a_reg;
    assign cmd_b     = cmd_b_reg;
    assign cmd_op    = cmd_op_reg;
    assign cmd_err   = cmd_err_reg;
    assign overrun   = overrun_reg;

endmodule
